mul_operand_feeder: RTL and testbench

//  Transmit side of the single-precision chained-multiply handshake.
//  - Buffers upstream FP32 operands and issues each job of N = cnt_max+1 operands on mul_stb/mul_data/mul_ack.
//  - Returns the chained product from the multiplier's output_z handshake to upstream.
//  - Sits between the operand source and the chained multiplier, which it feeds.

---
 rtl/mul_operand_feeder_pkg.sv | 23 ++
 rtl/mul_operand_feeder_if.sv | 23 ++
 rtl/mul_operand_feeder_fifo.sv | 49 ++++
 rtl/mul_operand_feeder.sv | 121 ++++++++++++
 tb/tb_mul_operand_feeder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_operand_feeder_pkg.sv
// Shared FSM state type and FP32 field constants for the chained-multiply operand feeder.
package mul_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

    localparam logic [FP_EXP_W-1:0] EXP_ALL_ONES = 8'hFF;
    localparam logic [FP_W-1:0]     FP_ONE       = 32'h3F800000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_Z = 2'd2,
        HOLD   = 2'd3
    } feed_state_t;

    // An all-ones exponent marks Inf or NaN.
    function automatic logic is_special(input logic [FP_W-1:0] value);
        return value[FP_W-2 -: FP_EXP_W] == EXP_ALL_ONES;
    endfunction

endpackage

// File: rtl/mul_operand_feeder_if.sv
// Operand and result handshake between the feeder (master) and the chained multiplier (slave).
interface mul_feed_if;
    import mul_pkg::*;

    logic            mul_stb;
    logic            mul_ack;
    logic [FP_W-1:0] mul_data;
    logic [2:0]      mul_cnt_max;
    logic            z_stb;
    logic [FP_W-1:0] z_data;
    logic            z_ack;

    modport master (
        output mul_stb, mul_data, mul_cnt_max, z_ack,
        input  mul_ack, z_stb, z_data
    );

    modport slave (
        input  mul_stb, mul_data, mul_cnt_max, z_ack,
        output mul_ack, z_stb, z_data
    );

endinterface

// File: rtl/mul_operand_feeder_fifo.sv
// Synchronous operand FIFO with show-ahead head and explicit occupancy count.
module mul_feed_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic [AW:0]  level,
    output logic         full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (level != '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; level disambiguates full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mul_operand_feeder.sv
// Feeds buffered FP32 operands to the chained multiplier and returns its product upstream.
// Optional MUL_FEED_SPECIAL_FLAG_EN adds res_special, flagging an Inf/NaN result.
module mul_operand_feeder
    import mul_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_data,
    input  logic [2:0]      cnt_max,
    mul_feed_if.master      mul,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [FP_W-1:0] res_data,
`ifdef MUL_FEED_SPECIAL_FLAG_EN
    output logic            res_special,
`endif
    output logic            busy,
    output logic [AW:0]     level
);

    feed_state_t     state;
    feed_state_t     state_nxt;
    logic [3:0]      rem;
    logic [2:0]      eff_cnt;
    logic [3:0]      job_len;
    logic [FP_W-1:0] head;
    logic            full;
    logic            push;
    logic            pop;
    logic            launch;
    logic            z_hs;

    // A zero job length would never produce a product, so it is treated as one multiply.
    assign eff_cnt = (cnt_max == 3'd0) ? 3'd1 : cnt_max;
    assign job_len = {1'b0, eff_cnt} + 4'd1;

    assign in_ready     = rst_n && !full;
    assign push         = in_valid && in_ready;
    assign pop          = (state == SEND) && mul.mul_ack;
    assign busy         = (state != IDLE);
    assign mul.mul_data = (state == SEND) ? head : '0;
    assign mul.z_ack    = (state == WAIT_Z) && mul.z_stb;
    assign z_hs         = mul.z_ack;

    mul_feed_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (FP_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .head  (head),
        .level (level),
        .full  (full)
    );

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (level >= (AW+1)'(job_len)) begin
                    launch    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND:    if (mul.mul_ack && rem == 4'd1) state_nxt = WAIT_Z;
            WAIT_Z:  if (mul.z_stb) state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            rem             <= '0;
            mul.mul_stb     <= 1'b0;
            mul.mul_cnt_max <= '0;
            res_valid       <= 1'b0;
            res_data        <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                rem             <= job_len;
                mul.mul_stb     <= 1'b1;
                mul.mul_cnt_max <= eff_cnt;
            end else if (pop) begin
                rem <= rem - 4'd1;
            end
            if (pop && rem == 4'd1) mul.mul_stb <= 1'b0;
            if (z_hs) begin
                res_data  <= mul.z_data;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef MUL_FEED_SPECIAL_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_special <= 1'b0;
        end else if (z_hs) begin
            res_special <= is_special(mul.z_data);
        end else if (res_valid && res_ready) begin
            res_special <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Directed self-checking bench for mul_operand_feeder; the bench plays the multiplier and upstream.
module tb_mul_operand_feeder;
    import mul_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  cnt_max;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;
    logic [4:0]  level;
`ifdef MUL_FEED_SPECIAL_FLAG_EN
    logic        res_special;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          push_idx;
    logic [31:0] sb [$];

    mul_feed_if mif ();

    mul_operand_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .cnt_max     (cnt_max),
        .mul         (mif),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
`ifdef MUL_FEED_SPECIAL_FLAG_EN
        .res_special (res_special),
`endif
        .busy        (busy),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] dword(input int i);
        return FP_ONE + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        mif.mul_ack = 1'b0;
        mif.z_stb = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic applyStimulus(input logic [31:0] d);
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
        sb.push_back(d);
    endtask

    task automatic launchCheck(input string tag, input logic [2:0] exp_cnt);
        checkOutput({tag, "_stb_pre"}, 32'(mif.mul_stb), 32'd0);
        tick();
        checkOutput({tag, "_stb"}, 32'(mif.mul_stb), 32'd1);
        checkOutput({tag, "_cnt"}, 32'(mif.mul_cnt_max), 32'(exp_cnt));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic ackCycle(input string tag, input bit also_push, input logic [31:0] pd);
        checkOutput({tag, "_stb"}, 32'(mif.mul_stb), 32'd1);
        checkOutput({tag, "_data"}, mif.mul_data, sb[0]);
        mif.mul_ack = 1'b1;
        if (also_push) begin
            in_valid = 1'b1;
            in_data = pd;
        end
        tick();
        void'(sb.pop_front());
        if (also_push) sb.push_back(pd);
        mif.mul_ack = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic returnResult(input string tag, input logic [31:0] z);
        logic [31:0] zz;
        zz = z;
        checkOutput({tag, "_stb_off"}, 32'(mif.mul_stb), 32'd0);
        checkOutput({tag, "_wait_busy"}, 32'(busy), 32'd1);
        mif.z_stb = 1'b1;
        mif.z_data = z;
        #1;
        checkOutput({tag, "_zack"}, 32'(mif.z_ack), 32'd1);
        tick();
        mif.z_stb = 1'b0;
        mif.z_data = '0;
        checkOutput({tag, "_rvalid"}, 32'(res_valid), 32'd1);
        checkOutput({tag, "_rdata"}, res_data, z);
`ifdef MUL_FEED_SPECIAL_FLAG_EN
        checkOutput({tag, "_special"}, 32'(res_special), 32'(zz[30:23] == 8'hFF));
`endif
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput({tag, "_rvalid_clr"}, 32'(res_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
`ifdef MUL_FEED_SPECIAL_FLAG_EN
        checkOutput({tag, "_special_clr"}, 32'(res_special), 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        cnt_max = 3'd1;
        res_ready = 1'b0;
        mif.mul_ack = 1'b0;
        mif.z_stb = 1'b0;
        mif.z_data = '0;

        $display("[TB] reset state");
        doReset();
        rst_n = 1'b0;
        tick();
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_stb", 32'(mif.mul_stb), 32'd0);
        checkOutput("rst_rvalid", 32'(res_valid), 32'd0);
        checkOutput("rst_rdata", res_data, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cnt", 32'(mif.mul_cnt_max), 32'd0);
        checkOutput("rst_mdata", mif.mul_data, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] test 1: two-operand job, ack every other cycle");
        cnt_max = 3'd1;
        applyStimulus(32'h40000000);
        applyStimulus(32'h40400000);
        launchCheck("t1_launch", 3'd1);
        tick();
        checkOutput("t1_gap_data", mif.mul_data, 32'h40000000);
        checkOutput("t1_gap_level", 32'(level), 32'd2);
        ackCycle("t1_pop0", 1'b0, '0);
        tick();
        checkOutput("t1_gap2_data", mif.mul_data, 32'h40400000);
        ackCycle("t1_pop1", 1'b0, '0);
        checkOutput("t1_level", 32'(level), 32'd0);
        returnResult("t1_res", 32'h40C00000);
        consume("t1_done");

        $display("[TB] test 2: four-operand job with push during SEND");
        cnt_max = 3'd3;
        for (int i = 0; i < 4; i++) applyStimulus(32'h40000000);
        launchCheck("t2_launch", 3'd3);
        ackCycle("t2_pop0", 1'b1, 32'h40A00000);
        checkOutput("t2_level_pp", 32'(level), 32'd4);
        for (int i = 1; i < 4; i++) ackCycle($sformatf("t2_pop%0d", i), 1'b0, '0);
        checkOutput("t2_level", 32'(level), 32'd1);
        mif.mul_ack = 1'b1;
        tick();
        mif.mul_ack = 1'b0;
        checkOutput("t2_ack_ignored", 32'(level), 32'd1);
        returnResult("t2_res", 32'h41800000);
        consume("t2_done");

        $display("[TB] test 3: launch waits for enough operands");
        cnt_max = 3'd2;
        applyStimulus(32'h41000000);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("t3_nolaunch%0d", i), 32'(mif.mul_stb), 32'd0);
            checkOutput($sformatf("t3_idle%0d", i), 32'(busy), 32'd0);
        end
        checkOutput("t3_level", 32'(level), 32'd2);
        applyStimulus(32'h41100000);
        launchCheck("t3_launch", 3'd2);
        for (int i = 0; i < 3; i++) ackCycle($sformatf("t3_pop%0d", i), 1'b0, '0);
        returnResult("t3_res", 32'h43B40000);
        consume("t3_done");

        $display("[TB] test 4: full FIFO, push+pop, pointer wrap");
        doReset();
        cnt_max = 3'd7;
        for (int i = 0; i < 16; i++) applyStimulus(dword(i));
        checkOutput("t4_full_level", 32'(level), 32'd16);
        checkOutput("t4_full_ready", 32'(in_ready), 32'd0);
        checkOutput("t4_stb", 32'(mif.mul_stb), 32'd1);
        checkOutput("t4_cnt", 32'(mif.mul_cnt_max), 32'd7);
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        checkOutput("t4_drop_level", 32'(level), 32'd16);
        ackCycle("t4_pop0", 1'b0, '0);
        checkOutput("t4_level15", 32'(level), 32'd15);
        checkOutput("t4_ready", 32'(in_ready), 32'd1);
        ackCycle("t4_pop1", 1'b1, dword(16));
        checkOutput("t4_pp_level", 32'(level), 32'd15);
        checkOutput("t4_pp_head", mif.mul_data, dword(2));
        for (int i = 2; i < 8; i++) ackCycle($sformatf("t4_pop%0d", i), 1'b0, '0);
        checkOutput("t4_level9", 32'(level), 32'd9);
        returnResult("t4_res0", 32'h3F800000);
        consume("t4_done0");
        push_idx = 17;
        for (int j = 1; j < 5; j++) begin
            launchCheck($sformatf("t4_launch%0d", j), 3'd7);
            for (int k = 0; k < 8; k++) begin
                ackCycle($sformatf("t4_j%0d_pop%0d", j, k), push_idx < 40, dword(push_idx));
                if (push_idx < 40) push_idx++;
            end
            returnResult($sformatf("t4_res%0d", j), dword(100 + j));
            consume($sformatf("t4_done%0d", j));
        end
        checkOutput("t4_empty", 32'(level), 32'd0);

        $display("[TB] test 5: result held under backpressure");
        doReset();
        cnt_max = 3'd1;
        applyStimulus(32'h40800000);
        applyStimulus(32'h40A00000);
        launchCheck("t5_launch", 3'd1);
        ackCycle("t5_pop0", 1'b0, '0);
        ackCycle("t5_pop1", 1'b0, '0);
        returnResult("t5_res", 32'h41A00000);
        applyStimulus(32'h40C00000);
        applyStimulus(32'h40E00000);
        mif.z_stb = 1'b1;
        #1;
        checkOutput("t5_zack_hold", 32'(mif.z_ack), 32'd0);
        mif.z_stb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t5_hold_rdata%0d", i), res_data, 32'h41A00000);
            checkOutput($sformatf("t5_hold_stb%0d", i), 32'(mif.mul_stb), 32'd0);
            checkOutput($sformatf("t5_hold_rvalid%0d", i), 32'(res_valid), 32'd1);
            tick();
        end
        checkOutput("t5_level", 32'(level), 32'd2);
        consume("t5_done");
        launchCheck("t5_relaunch", 3'd1);

        $display("[TB] test 6: reset in the middle of SEND");
        ackCycle("t6_pop0", 1'b0, '0);
        checkOutput("t6_level_pre", 32'(level), 32'd1);
        rst_n = 1'b0;
        tick();
        checkOutput("t6_level", 32'(level), 32'd0);
        checkOutput("t6_stb", 32'(mif.mul_stb), 32'd0);
        checkOutput("t6_rvalid", 32'(res_valid), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        sb.delete();
        #1;
        checkOutput("t6_ready", 32'(in_ready), 32'd1);

        $display("[TB] test 7: cnt_max=0 clamps to one multiply, Inf result");
        cnt_max = 3'd0;
        applyStimulus(FP_ONE);
        applyStimulus(32'h40000000);
        launchCheck("t7_launch", 3'd1);
        ackCycle("t7_pop0", 1'b0, '0);
        ackCycle("t7_pop1", 1'b0, '0);
        checkOutput("t7_level", 32'(level), 32'd0);
        returnResult("t7_res", 32'h7F800000);
        consume("t7_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
